// File: rtl/mul_io_pkg.sv
// Shared types and sizes for the big-number multiplier 32-bit word I/O paths.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the word width, product/operand word counts, the serializer state
// type and the 32-bit word type used by both the packing and unpacking sides.
package mul_io_pkg;

    localparam int WORD_W     = 32;
    localparam int PROD_WORDS = 64;   // 2048-bit product
    localparam int OPND_WORDS = 32;   // 1024-bit operand

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/msw_finder.sv
// Finds the index of the most significant nonzero word of a wide value.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of in_data.
//
// Ports:
//   in_data  wide value, word k = in_data[k*WORD_W +: WORD_W]
//   msw_idx  index of the highest nonzero word (0 when the value is all zero)
module msw_finder #(
    parameter int WORDS  = 64,
    parameter int WORD_W = 32
) (
    input  logic [WORDS*WORD_W-1:0]                        in_data,
    output logic [((WORDS > 1) ? $clog2(WORDS) : 1)-1:0]   msw_idx
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Ascending scan: the last nonzero word hit wins, which is the highest one.
    always_comb begin
        msw_idx = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (in_data[k*WORD_W +: WORD_W] != '0) begin
                msw_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/wide_word_serializer.sv
// Serializes one captured wide product into WORD_W-bit words, LS word first, each tagged with its index.
// Latency: first word valid 1 cycle after capture; one word per cycle while out_ready is high.
// Backpressure: out_ready low freezes all out_* outputs; in_ready is low for the whole transfer.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   in_valid/in_ready    capture handshake for in_data (accepted only in IDLE)
//   in_data              wide value, word k = in_data[k*WORD_W +: WORD_W]
//   out_valid/out_ready  word handshake
//   out_data/out_index   current word and its index
//   out_last             current word is the final one of this value
//   busy                 a value is being transmitted
//
// Build option: define SER_ZERO_SUPPRESS_EN to stop each transfer at the highest
// nonzero word (an all-zero value sends a single zero word). Without it every
// word is sent.
module wide_word_serializer
    import mul_io_pkg::*;
#(
    parameter int WORDS  = PROD_WORDS,
    parameter int WORD_W = mul_io_pkg::WORD_W,
    parameter int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORDS*WORD_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_W-1:0]         out_data,
    output logic [IDX_W-1:0]          out_index,
    output logic                      out_last,
    output logic                      busy
);

    ser_state_t                    state;
    logic [WORDS-1:0][WORD_W-1:0]  shadow;
    logic [IDX_W-1:0]              idx;
    logic [IDX_W-1:0]              last_idx;
    logic [IDX_W-1:0]              cap_last_idx;
    logic                          take_in;
    logic                          take_out;

    assign take_in  = (state == IDLE) && in_valid;
    assign take_out = (state == SEND) && out_ready;

`ifdef SER_ZERO_SUPPRESS_EN
    msw_finder #(
        .WORDS  (WORDS),
        .WORD_W (WORD_W)
    ) u_msw_finder (
        .in_data (in_data),
        .msw_idx (cap_last_idx)
    );
`else
    assign cap_last_idx = IDX_W'(WORDS - 1);
`endif

    // Control FSM. Handshake flags and out_last are registered so they come
    // straight off flops; out_last for the next word is looked ahead from idx+1.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            idx       <= '0;
            last_idx  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_in) begin
                        state     <= SEND;
                        idx       <= '0;
                        last_idx  <= cap_last_idx;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_last  <= (cap_last_idx == '0);
                    end
                end
                SEND: begin
                    if (take_out) begin
                        if (idx == last_idx) begin
                            state     <= IDLE;
                            idx       <= '0;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            idx      <= idx + 1'b1;
                            out_last <= ((idx + 1'b1) == last_idx);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    // Shadow register is only written on capture, so it is stable for the
    // whole SEND phase. Its content after reset is don't-care: out_data is
    // gated by out_valid below.
    always_ff @(posedge clk) begin
        if (take_in) begin
            shadow <= in_data;
        end
    end

    assign out_data  = out_valid ? shadow[idx] : '0;
    assign out_index = idx;

endmodule

// File: tb/tb_wide_word_serializer.sv
// Self-checking bench for wide_word_serializer: a scoreboard of expected words
// is filled at capture time and drained by a monitor at every accepted word.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_wide_word_serializer;

    localparam int WORDS = 64;
    localparam int WW    = 32;
    localparam int IW    = 6;

    typedef struct packed {
        logic [WW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    logic                  clk;
    logic                  resetn;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORDS*WW-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WW-1:0]         out_data;
    logic [IW-1:0]         out_index;
    logic                  out_last;
    logic                  busy;

    int   errors   = 0;
    int   checks   = 0;
    int   rx_count = 0;
    exp_t sb[$];
    logic rdy_random = 1'b0;
    logic [3:0] rdy_pat = 4'b1001;

    wide_word_serializer dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Index of the last word the serializer should send for value v.
    function automatic int model_last(input logic [WORDS*WW-1:0] v);
        int l;
`ifdef SER_ZERO_SUPPRESS_EN
        l = 0;
        for (int k = 0; k < WORDS; k++)
            if (v[k*WW +: WW] != '0) l = k;
`else
        l = WORDS - 1;
`endif
        return l;
    endfunction

    function automatic logic [WORDS*WW-1:0] make_val(input int seed);
        logic [WORDS*WW-1:0] v;
        logic [15:0] s;
        s = seed[15:0];
        for (int k = 0; k < WORDS; k++)
            v[k*WW +: WW] = {s, 16'(k + 1)};
        return v;
    endfunction

    task automatic push_expected(input logic [WORDS*WW-1:0] v);
        exp_t e;
        int   l;
        l = model_last(v);
        for (int k = 0; k <= l; k++) begin
            e.data = v[k*WW +: WW];
            e.idx  = IW'(k);
            e.last = (k == l);
            sb.push_back(e);
        end
    endtask

    // Scoreboard monitor: pops one expected word per accepted word and checks
    // that a stalled word is still presented unchanged on the next cycle.
    task automatic monitor();
        exp_t          e;
        logic          stalled = 1'b0;
        logic [WW-1:0] hd = '0;
        logic [IW-1:0] hi = '0;
        logic          hl = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn !== 1'b1) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== hd || out_index !== hi || out_last !== hl) begin
                        errors++;
                        $display("FAIL stall_hold: got vld=%b data=%h idx=%0d last=%b, required vld=1 data=%h idx=%0d last=%b",
                                 out_valid, out_data, out_index, out_last, hd, hi, hl);
                    end
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    checks++;
                    rx_count++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: got idx=%0d data=%h, required no word", out_index, out_data);
                    end else begin
                        e = sb.pop_front();
                        if (out_data !== e.data || out_index !== e.idx || out_last !== e.last) begin
                            errors++;
                            $display("FAIL word: got data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b",
                                     out_data, out_index, out_last, e.data, e.idx, e.last);
                        end
                    end
                end
                stalled = (out_valid === 1'b1 && out_ready === 1'b0);
                hd = out_data;
                hi = out_index;
                hl = out_last;
            end
        end
    endtask

    // Starts and ends 1 unit after a rising edge.
    task automatic load_value(input logic [WORDS*WW-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        push_expected(v);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready: got in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        logic r;
        logic done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            r = 1'b1;
            if (rdy_random) begin
                r = rdy_pat[c % 4];
                if ($urandom_range(0, 3) == 0) r = ~r;
            end
            out_ready = r;
            @(negedge clk);
            if (sb.size() == 0 && out_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (done) begin
            @(posedge clk); #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words outstanding, required 0", sb.size());
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (in_ready  !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++; if (out_data  !== '0)   begin errors++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
        checks++; if (out_index !== '0)   begin errors++; $display("FAIL reset_out_index: got %0d, required 0", out_index); end
        checks++; if (out_last  !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b, required 0", out_last); end
        checks++; if (busy      !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        @(posedge clk); #1;
    endtask

    // Word k = k+1, consumer always ready: 64 words on consecutive cycles.
    task automatic test_stream();
        logic [WORDS*WW-1:0] v;
        int vld_cnt = 0;
        int rx0;
        for (int k = 0; k < WORDS; k++) v[k*WW +: WW] = 32'(k + 1);
        rx0 = rx_count;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = v;
        push_expected(v);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_pre: got %b, required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stream_latency: got vld=%b busy=%b rdy=%b, required vld=1 busy=1 rdy=0", out_valid, busy, in_ready);
        end
        for (int c = 0; c < WORDS; c++) begin
            if (c != 0) @(negedge clk);
            if (out_valid === 1'b1) vld_cnt++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (vld_cnt != WORDS) begin errors++; $display("FAIL stream_consecutive: got %0d valid cycles, required %0d", vld_cnt, WORDS); end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: got rdy=%b vld=%b busy=%b, required rdy=1 vld=0 busy=0", in_ready, out_valid, busy);
        end
        checks++;
        if (rx_count - rx0 != WORDS || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_count: got %0d words (%0d left), required %0d (0 left)", rx_count - rx0, sb.size(), WORDS);
        end
        @(posedge clk); #1;
    endtask

    // Random consumer stalls; in_ready must stay low for the whole transfer.
    task automatic test_backpressure();
        logic [WORDS*WW-1:0] v;
        logic r;
        int bad = 0;
        int rx0;
        logic done = 1'b0;
        for (int k = 0; k < WORDS; k++) v[k*WW +: WW] = 32'(k + 1);
        rx0 = rx_count;
        load_value(v);
        for (int c = 0; c < 1000; c++) begin
            r = rdy_pat[c % 4];
            if ($urandom_range(0, 3) == 0) r = ~r;
            out_ready = r;
            @(negedge clk);
            if (out_valid === 1'b1 && (in_ready !== 1'b0 || busy !== 1'b1)) bad++;
            if (sb.size() == 0 && out_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL bp_timeout: got %0d words outstanding, required 0", sb.size()); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_in_ready: got %0d cycles with in_ready/busy wrong, required 0", bad); end
        checks++;
        if (rx_count - rx0 != WORDS) begin errors++; $display("FAIL bp_count: got %0d words, required %0d", rx_count - rx0, WORDS); end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    // in_valid held with new data during SEND: second value waits for the first to finish.
    task automatic test_hold_input();
        logic [WORDS*WW-1:0] a;
        logic [WORDS*WW-1:0] b;
        int phase = 0;
        int bad = 0;
        int rx0;
        a = make_val(16'hA5A5);
        b = make_val(16'h5A5A);
        rx0 = rx_count;
        out_ready = 1'b1;
        load_value(a);
        in_valid = 1'b1;
        in_data  = b;
        push_expected(b);
        for (int c = 0; c < 200 && phase < 3; c++) begin
            @(negedge clk);
            if (phase == 0) begin
                if (in_ready !== 1'b0) bad++;
                if (out_valid === 1'b1 && out_ready === 1'b1 && out_last === 1'b1) phase = 1;
            end else if (phase == 1) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_recapture_ready: got %b, required 1", in_ready); end
                phase = 2;
            end else begin
                checks++;
                if (out_valid !== 1'b1 || out_index !== '0) begin
                    errors++;
                    $display("FAIL hold_second_start: got vld=%b idx=%0d, required vld=1 idx=0", out_valid, out_index);
                end
                phase = 3;
            end
            @(posedge clk); #1;
            if (phase == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (phase != 3) begin errors++; $display("FAIL hold_timeout: got phase %0d, required 3", phase); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_in_ready: got %0d cycles with in_ready=1 during SEND, required 0", bad); end
        wait_drain(200);
        checks++;
        if (rx_count - rx0 != 2 * WORDS) begin errors++; $display("FAIL hold_count: got %0d words, required %0d", rx_count - rx0, 2 * WORDS); end
    endtask

    // One-cycle reset while word 20 is on the output.
    task automatic test_reset_mid();
        logic found = 1'b0;
        out_ready = 1'b1;
        load_value(make_val(16'h1234));
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_index === 6'd19) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        checks++;
        if (!found || out_index !== 6'd20) begin
            errors++;
            $display("FAIL rst_mid_reach: got idx=%0d, required 20", out_index);
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_index !== '0) begin
            errors++;
            $display("FAIL rst_mid_state: got vld=%b rdy=%b busy=%b idx=%0d, required vld=0 rdy=1 busy=0 idx=0",
                     out_valid, in_ready, busy, out_index);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_values();
        logic [WORDS*WW-1:0] v;
        int rx0;
        int exp_short;
        int exp_zero;
`ifdef SER_ZERO_SUPPRESS_EN
        exp_short = 3;
        exp_zero  = 1;
`else
        exp_short = WORDS;
        exp_zero  = WORDS;
`endif
        v = '0;
        v[31:0]  = 32'h0000_0003;
        v[63:32] = 32'h0000_0002;
        v[95:64] = 32'h0000_0001;
        rx0 = rx_count;
        load_value(v);
        wait_drain(200);
        checks++;
        if (rx_count - rx0 != exp_short) begin errors++; $display("FAIL short_count: got %0d words, required %0d", rx_count - rx0, exp_short); end

        v = '0;
        rx0 = rx_count;
        rdy_random = 1'b1;
        load_value(v);
        wait_drain(400);
        rdy_random = 1'b0;
        checks++;
        if (rx_count - rx0 != exp_zero) begin errors++; $display("FAIL zero_count: got %0d words, required %0d", rx_count - rx0, exp_zero); end
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_stream();
        test_backpressure();
        test_hold_input();
        test_reset_mid();
        test_zero_values();
        // Back-to-back random values with random stalls.
        rdy_random = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_value(make_val(int'($urandom_range(1, 65535))));
            wait_drain(600);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL final_scoreboard: got %0d words left, required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
